// File: rtl/line_follow_if.sv
// Control and status bundle between the line-follow controller and its host.
interface line_follow_if;
  logic       start;
  logic       stop;
  logic [7:0] cross_target;
  logic       iL;
  logic       iLC;
  logic       iC;
  logic       iRC;
  logic       iR;
  logic [1:0] mot_l;
  logic [1:0] mot_r;
  logic [2:0] state;
  logic [7:0] cross_cnt;
  logic       done;
  logic       lost;

  modport master (
    output start, stop, cross_target, iL, iLC, iC, iRC, iR,
    input  mot_l, mot_r, state, cross_cnt, done, lost
  );

  modport slave (
    input  start, stop, cross_target, iL, iLC, iC, iRC, iR,
    output mot_l, mot_r, state, cross_cnt, done, lost
  );
endinterface

// File: rtl/line_follow_ctrl.sv
// Line-follow robot controller: synchronises and debounces five IR sensors
// on a sample tick and steers two motors through a small run FSM.
//
// state  | meaning
// IDLE   | motors stopped, waiting for start; cross_cnt holds last run
// FOLLOW | tracking the line from the filtered sensor vector
// CROSS  | driving straight over an intersection (all sensors lit)
// LOST   | no line seen, spinning toward the last known side
// HALT   | search timed out, motors stopped until start
module line_follow_ctrl #(
  parameter int SAMPLE_DIV   = 1000,
  parameter int DEB_N        = 4,
  parameter int LOST_TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  line_follow_if.slave bus
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(DEB_N + 1);
  localparam int TW = $clog2(LOST_TIMEOUT + 1);

  localparam logic [PW-1:0] PRESC_RELOAD = PW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] DEB_MAX      = SW'(DEB_N);
  localparam logic [TW-1:0] LOST_MAX     = TW'(LOST_TIMEOUT);

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  localparam logic [4:0] F_ALL  = 5'b11111;
  localparam logic [4:0] F_NONE = 5'b00000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FOLLOW = 3'd1,
    S_CROSS  = 3'd2,
    S_LOST   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  logic [4:0]    w_raw;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [4:0]    r_prev_v;
  logic [SW-1:0] r_stab;
  logic [SW-1:0] w_stab_nxt;
  logic [4:0]    r_f;
  logic [4:0]    w_f_nxt;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_mot_l;
  logic [1:0]    r_mot_r;
  logic [1:0]    w_mot_l_nxt;
  logic [1:0]    w_mot_r_nxt;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nxt;
  logic [7:0]    w_cnt_inc;
  logic          r_done;
  logic          w_done_nxt;
  logic          r_dir_right;
  logic          w_dir_right_nxt;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_nxt;
  logic [TW-1:0] w_tmr_inc;

  logic [1:0]    w_map_l;
  logic [1:0]    w_map_r;
  logic          w_map_dir_right;

  assign w_raw  = {bus.iL, bus.iLC, bus.iC, bus.iRC, bus.iR};
  assign w_tick = (r_presc == '0);

  // Stability count restarts at 1 on any change; F only moves once DEB_N equal samples agree.
  always_comb begin
    w_stab_nxt = r_stab;
    w_f_nxt    = r_f;
    if (w_tick) begin
      if (r_sync2 == r_prev_v) begin
        w_stab_nxt = (r_stab == DEB_MAX) ? DEB_MAX : r_stab + 1'b1;
      end else begin
        w_stab_nxt = SW'(1);
      end
      if (w_stab_nxt == DEB_MAX) begin
        w_f_nxt = r_sync2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_presc  <= '0;
      r_prev_v <= '0;
      r_stab   <= '0;
      r_f      <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_presc <= w_tick ? PRESC_RELOAD : r_presc - 1'b1;
      if (w_tick) begin
        r_prev_v <= r_sync2;
        r_stab   <= w_stab_nxt;
        r_f      <= w_f_nxt;
      end
    end
  end

  // Steering table; unlisted patterns keep the current command.
  always_comb begin
    w_map_l         = r_mot_l;
    w_map_r         = r_mot_r;
    w_map_dir_right = r_dir_right;
    case (w_f_nxt)
      5'b00100, 5'b01110: begin
        w_map_l = MOT_FWD;
        w_map_r = MOT_FWD;
      end
      5'b01100, 5'b01000: begin
        w_map_l = MOT_STOP;
        w_map_r = MOT_FWD;
      end
      5'b11000, 5'b10000: begin
        w_map_l         = MOT_REV;
        w_map_r         = MOT_FWD;
        w_map_dir_right = 1'b0;
      end
      5'b00110, 5'b00010: begin
        w_map_l = MOT_FWD;
        w_map_r = MOT_STOP;
      end
      5'b00011, 5'b00001: begin
        w_map_l         = MOT_FWD;
        w_map_r         = MOT_REV;
        w_map_dir_right = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
  assign w_tmr_inc = r_tmr + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_mot_l_nxt     = r_mot_l;
    w_mot_r_nxt     = r_mot_r;
    w_cnt_nxt       = r_cnt;
    w_done_nxt      = 1'b0;
    w_dir_right_nxt = r_dir_right;
    w_tmr_nxt       = r_tmr;

    if (bus.stop) begin
      w_state_nxt = S_IDLE;
      w_mot_l_nxt = MOT_STOP;
      w_mot_r_nxt = MOT_STOP;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          w_mot_l_nxt = MOT_STOP;
          w_mot_r_nxt = MOT_STOP;
          if (bus.start) begin
            w_state_nxt = S_FOLLOW;
            w_tmr_nxt   = '0;
            if (r_state == S_IDLE) begin
              w_cnt_nxt = 8'd0;
            end
          end
        end
        S_CROSS: begin
          if (w_tick && (w_f_nxt != F_ALL)) begin
            w_state_nxt     = S_FOLLOW;
            w_mot_l_nxt     = w_map_l;
            w_mot_r_nxt     = w_map_r;
            w_dir_right_nxt = w_map_dir_right;
          end
        end
        S_FOLLOW, S_LOST: begin
          if (w_tick) begin
            if (w_f_nxt == F_ALL) begin
              w_cnt_nxt = w_cnt_inc;
              if ((bus.cross_target != 8'd0) && (w_cnt_inc == bus.cross_target)) begin
                w_state_nxt = S_IDLE;
                w_mot_l_nxt = MOT_STOP;
                w_mot_r_nxt = MOT_STOP;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = S_CROSS;
                w_mot_l_nxt = MOT_FWD;
                w_mot_r_nxt = MOT_FWD;
              end
            end else if (w_f_nxt == F_NONE) begin
              if (r_state == S_FOLLOW) begin
                w_state_nxt = S_LOST;
                w_tmr_nxt   = '0;
                w_mot_l_nxt = r_dir_right ? MOT_FWD : MOT_REV;
                w_mot_r_nxt = r_dir_right ? MOT_REV : MOT_FWD;
              end else if (w_tmr_inc >= LOST_MAX) begin
                w_state_nxt = S_HALT;
                w_tmr_nxt   = w_tmr_inc;
                w_mot_l_nxt = MOT_STOP;
                w_mot_r_nxt = MOT_STOP;
              end else begin
                w_tmr_nxt = w_tmr_inc;
              end
            end else begin
              w_state_nxt     = S_FOLLOW;
              w_mot_l_nxt     = w_map_l;
              w_mot_r_nxt     = w_map_r;
              w_dir_right_nxt = w_map_dir_right;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_mot_l_nxt = MOT_STOP;
          w_mot_r_nxt = MOT_STOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mot_l     <= MOT_STOP;
      r_mot_r     <= MOT_STOP;
      r_cnt       <= 8'd0;
      r_done      <= 1'b0;
      r_dir_right <= 1'b0;
      r_tmr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mot_l     <= w_mot_l_nxt;
      r_mot_r     <= w_mot_r_nxt;
      r_cnt       <= w_cnt_nxt;
      r_done      <= w_done_nxt;
      r_dir_right <= w_dir_right_nxt;
      r_tmr       <= w_tmr_nxt;
    end
  end

  assign bus.mot_l     = r_mot_l;
  assign bus.mot_r     = r_mot_r;
  assign bus.state     = r_state;
  assign bus.cross_cnt = r_cnt;
  assign bus.done      = r_done;
  assign bus.lost      = (r_state == S_LOST) || (r_state == S_HALT);

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl with a short sample period and debounce.
module tb_line_follow_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  line_follow_if bus ();

  line_follow_ctrl #(
    .SAMPLE_DIV  (4),
    .DEB_N       (2),
    .LOST_TIMEOUT(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic set_sensors(input logic [4:0] v);
    {bus.iL, bus.iLC, bus.iC, bus.iRC, bus.iR} = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) bus.stop = 1'b1;
    @(negedge clk) bus.stop = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int i = 0;
    while ((bus.state !== s) && (i < budget)) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic wait_mot(input logic [1:0] l, input logic [1:0] r, input int budget);
    int i = 0;
    while (((bus.mot_l !== l) || (bus.mot_r !== r)) && (i < budget)) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic run_from_idle(input logic [4:0] v);
    pulse_stop();
    set_sensors(v);
    cycles(12);
    pulse_start();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.cross_target = 8'd0;
    set_sensors(5'b00000);
    #12;
    n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.mot_l !== 2'b00) begin n_err++; $display("FAIL reset_mot_l: got %b want 00", bus.mot_l); end
    n_cmp++; if (bus.mot_r !== 2'b00) begin n_err++; $display("FAIL reset_mot_r: got %b want 00", bus.mot_r); end
    n_cmp++; if (bus.cross_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.cross_cnt); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.lost !== 1'b0) begin n_err++; $display("FAIL reset_lost: got %b want 0", bus.lost); end
    @(negedge clk) rst_n = 1'b1;
    cycles(8);
    n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL idle_after_reset: got %0d want 0", bus.state); end
  endtask

  task automatic test_follow_glitch();
    logic changed;
    set_sensors(5'b00100);
    cycles(12);
    n_cmp++; if (bus.mot_l !== 2'b00) begin n_err++; $display("FAIL idle_mot: got %b want 00", bus.mot_l); end
    pulse_start();
    n_cmp++; if (bus.state !== 3'd1) begin n_err++; $display("FAIL start_follow: got %0d want 1", bus.state); end
    wait_mot(2'b01, 2'b01, 11);
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0101) begin n_err++; $display("FAIL follow_center: got %b/%b want 01/01", bus.mot_l, bus.mot_r); end
    changed = 1'b0;
    set_sensors(5'b11000);
    repeat (4) begin
      @(negedge clk);
      if ({bus.mot_l, bus.mot_r} != 4'b0101) changed = 1'b1;
    end
    set_sensors(5'b00100);
    repeat (16) begin
      @(negedge clk);
      if ({bus.mot_l, bus.mot_r} != 4'b0101) changed = 1'b1;
    end
    n_cmp++; if (changed !== 1'b0) begin n_err++; $display("FAIL glitch_filter: motor changed=%b want 0", changed); end
  endtask

  task automatic test_lost_halt();
    int n;
    set_sensors(5'b10000);
    wait_mot(2'b10, 2'b01, 16);
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b1001) begin n_err++; $display("FAIL hard_left: got %b/%b want 10/01", bus.mot_l, bus.mot_r); end
    set_sensors(5'b00000);
    wait_state(3'd3, 16);
    n_cmp++; if (bus.state !== 3'd3) begin n_err++; $display("FAIL enter_lost: got %0d want 3", bus.state); end
    n_cmp++; if (bus.lost !== 1'b1) begin n_err++; $display("FAIL lost_flag: got %b want 1", bus.lost); end
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b1001) begin n_err++; $display("FAIL lost_spin_left: got %b/%b want 10/01", bus.mot_l, bus.mot_r); end
    n = 0;
    while ((bus.state === 3'd3) && (n < 30)) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== 12) begin n_err++; $display("FAIL lost_timeout_cycles: got %0d want 12", n); end
    n_cmp++; if (bus.state !== 3'd4) begin n_err++; $display("FAIL enter_halt: got %0d want 4", bus.state); end
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0000) begin n_err++; $display("FAIL halt_mot: got %b/%b want 00/00", bus.mot_l, bus.mot_r); end
    pulse_start();
    n_cmp++; if (bus.state !== 3'd1) begin n_err++; $display("FAIL halt_restart: got %0d want 1", bus.state); end
  endtask

  task automatic test_direction();
    run_from_idle(5'b00110);
    wait_mot(2'b01, 2'b00, 8);
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0100) begin n_err++; $display("FAIL soft_right: got %b/%b want 01/00", bus.mot_l, bus.mot_r); end
    set_sensors(5'b00011);
    wait_mot(2'b01, 2'b10, 16);
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0110) begin n_err++; $display("FAIL hard_right: got %b/%b want 01/10", bus.mot_l, bus.mot_r); end
    set_sensors(5'b00000);
    wait_state(3'd3, 16);
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0110) begin n_err++; $display("FAIL lost_spin_right: got %b/%b want 01/10", bus.mot_l, bus.mot_r); end
    set_sensors(5'b01100);
    wait_state(3'd1, 16);
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0001) begin n_err++; $display("FAIL recover_soft_left: got %b/%b want 00/01", bus.mot_l, bus.mot_r); end
  endtask

  task automatic test_cross_target();
    bus.cross_target = 8'd2;
    run_from_idle(5'b00100);
    wait_mot(2'b01, 2'b01, 8);
    set_sensors(5'b11111);
    wait_state(3'd2, 16);
    n_cmp++; if (bus.cross_cnt !== 8'd1) begin n_err++; $display("FAIL cross_cnt_1: got %0d want 1", bus.cross_cnt); end
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0101) begin n_err++; $display("FAIL cross_mot: got %b/%b want 01/01", bus.mot_l, bus.mot_r); end
    set_sensors(5'b00100);
    wait_state(3'd1, 16);
    n_cmp++; if (bus.state !== 3'd1) begin n_err++; $display("FAIL cross_exit: got %0d want 1", bus.state); end
    set_sensors(5'b11111);
    begin
      int i = 0;
      while ((bus.done !== 1'b1) && (i < 16)) begin
        @(negedge clk);
        i++;
      end
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL done_pulse: got %b want 1", bus.done); end
    n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL target_idle: got %0d want 0", bus.state); end
    n_cmp++; if (bus.cross_cnt !== 8'd2) begin n_err++; $display("FAIL cross_cnt_2: got %0d want 2", bus.cross_cnt); end
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0000) begin n_err++; $display("FAIL target_mot: got %b/%b want 00/00", bus.mot_l, bus.mot_r); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
  endtask

  task automatic test_start_stop();
    @(negedge clk) begin bus.start = 1'b1; bus.stop = 1'b1; end
    @(negedge clk) begin bus.start = 1'b0; bus.stop = 1'b0; end
    n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL stop_wins: got %0d want 0", bus.state); end
    pulse_start();
    n_cmp++; if (bus.cross_cnt !== 8'd0) begin n_err++; $display("FAIL start_clears_cnt: got %0d want 0", bus.cross_cnt); end
    wait_state(3'd2, 8);
    n_cmp++; if (bus.cross_cnt !== 8'd1) begin n_err++; $display("FAIL recross_cnt: got %0d want 1", bus.cross_cnt); end
    pulse_stop();
    n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL stop_in_cross: got %0d want 0", bus.state); end
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0000) begin n_err++; $display("FAIL stop_mot: got %b/%b want 00/00", bus.mot_l, bus.mot_r); end
    cycles(8);
    n_cmp++; if (bus.cross_cnt !== 8'd1) begin n_err++; $display("FAIL idle_holds_cnt: got %0d want 1", bus.cross_cnt); end
  endtask

  task automatic test_reset_mid_run();
    bus.cross_target = 8'd0;
    run_from_idle(5'b11111);
    wait_state(3'd2, 8);
    set_sensors(5'b00000);
    wait_state(3'd3, 24);
    n_cmp++; if (bus.lost !== 1'b1) begin n_err++; $display("FAIL pre_reset_lost: got %b want 1", bus.lost); end
    n_cmp++; if (bus.cross_cnt !== 8'd1) begin n_err++; $display("FAIL pre_reset_cnt: got %0d want 1", bus.cross_cnt); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL async_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.lost !== 1'b0) begin n_err++; $display("FAIL async_lost: got %b want 0", bus.lost); end
    n_cmp++; if ({bus.mot_l, bus.mot_r} !== 4'b0000) begin n_err++; $display("FAIL async_mot: got %b/%b want 00/00", bus.mot_l, bus.mot_r); end
    n_cmp++; if (bus.cross_cnt !== 8'd0) begin n_err++; $display("FAIL async_cnt: got %0d want 0", bus.cross_cnt); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL async_done: got %b want 0", bus.done); end
    cycles(2);
    @(negedge clk) rst_n = 1'b1;
    set_sensors(5'b00100);
    cycles(16);
    n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL wait_for_start: got %0d want 0", bus.state); end
  endtask

  initial begin
    test_reset();
    test_follow_glitch();
    test_lost_halt();
    test_direction();
    test_cross_target();
    test_start_stop();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
